data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256, meaning data RAM depth in 32-bit words.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning pixel-word FIFO depth.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port addr  input  32  byte address from CPU memory stage.
REQ-006 SHALL have port write_enable  input  1  CPU store strobe.
REQ-007 SHALL have port read_enable  input  1  CPU load strobe (MemToReg of memory stage).
REQ-008 SHALL have port write_data  input  32  CPU store data.
REQ-009 SHALL have port read_data  output  32  load data to CPU.
REQ-010 SHALL have port pix_valid  input  1  camera byte valid.
REQ-011 SHALL have port pix_data  input  8  camera pixel byte.
REQ-012 SHALL have port pix_ready  output  1  responder accepts pix_data this cycle.

Function
REQ-013 SHALL decode addr[1:0] as ignored; all accesses are word-wide.
REQ-014 SHALL map 0x0000_0000..(RAM_WORDS*4-1) to RAM; combinational read, write on edge when write_enable is high.
REQ-015 SHALL map STATUS at 0x1000, read-only: bit0 fifo_empty, bit1 fifo_full, bits[7:4] word count (0..FIFO_DEPTH), bits[9:8] packer byte count; other bits 0.
REQ-016 SHALL map PIXEL at 0x1004: read_data = FIFO head word; pop on edge when read_enable is high and FIFO is non-empty.
REQ-017 SHALL map CTRL at 0x1008, write-only: bit1=1 flushes FIFO and packer on that edge; reads return 0.
REQ-018 SHALL map CYCLES at 0x100C: free-running 32-bit up-counter, wraps 0xFFFF_FFFF->0; a write loads write_data, and the counter increments from that value on the following edges.
REQ-019 SHALL return 0 on read of any unmapped address and ignore writes to it.
REQ-020 SHALL pack pixels little-endian: the first byte goes to [7:0] and the fourth to [31:24]; on acceptance of the fourth byte the word is pushed on the same edge.
REQ-021 SHALL drive pix_ready = !(packer_count==3 && fifo_full), with no bypass from a same-cycle pop.
REQ-022 SHALL accept a byte only when pix_valid && pix_ready.
REQ-023 SHALL leave count unchanged on a simultaneous push and pop of a non-full, non-empty FIFO.
REQ-024 SHALL return PIXEL read_data 0 on a pop of an empty FIFO, with no state change.
REQ-025 SHALL give a flush priority over a same-cycle push/pop; the accepted byte is discarded.
REQ-026 SHALL wrap FIFO pointers modulo FIFO_DEPTH.

Reset
REQ-027 SHALL, on reset low, asynchronously clear FIFO pointers/count, packer count/data and CYCLES to 0.
REQ-028 SHALL leave RAM contents undefined and not reset.
REQ-029 SHALL, while in reset, show STATUS=0x0000_0001 and pix_ready=1.

Structure
REQ-030 SHALL place address constants (STATUS/PIXEL/CTRL/CYCLES) and default depths in shared package dmem_pkg.
REQ-031 SHALL implement the FIFO as sub-module pixel_fifo (push, pop, flush, head, count, full, empty).

Verification
REQ-032 SHALL cover: store 0xDEADBEEF to 0x10, then load 0x10 -> read_data=0xDEADBEEF; load 0x14 returns last written value.
REQ-033 SHALL cover: bytes 0x11,0x22,0x33,0x44 -> STATUS[7:4]=1; PIXEL read -> 0x44332211; next STATUS=0x0000_0001.
REQ-034 SHALL cover: 35 bytes, no pops -> full after 32 bytes; STATUS[9:8]=3 after the 35th byte; pix_ready=0 and the 36th byte stalls until a PIXEL pop.
REQ-035 SHALL cover: a CTRL write of 0x2 on the same edge as a fourth-byte push -> STATUS=0x0000_0001.
REQ-036 SHALL cover: write CYCLES=0xFFFF_FFFE, read two cycles later -> 0x0000_0000 (wrap).
REQ-037 SHALL cover: assert reset mid-packing (2 bytes held) -> STATUS=0x0000_0001 immediately, without a clock edge.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared constants for the data-memory responder: register addresses,
// default depths, the CTRL flush bit position and the address decoder.
// Ports: none (package).
package dmem_pkg;

    localparam logic [31:0] STATUS_ADDR = 32'h0000_1000;
    localparam logic [31:0] PIXEL_ADDR  = 32'h0000_1004;
    localparam logic [31:0] CTRL_ADDR   = 32'h0000_1008;
    localparam logic [31:0] CYCLES_ADDR = 32'h0000_100C;

    localparam int DEFAULT_RAM_WORDS  = 256;
    localparam int DEFAULT_FIFO_DEPTH = 8;

    localparam int CTRL_FLUSH_BIT = 1;

    typedef enum logic [2:0] {
        REGION_RAM,
        REGION_STATUS,
        REGION_PIXEL,
        REGION_CTRL,
        REGION_CYCLES,
        REGION_NONE
    } region_e;

    // Byte-lane bits are dropped before comparing; every access is a word.
    // Registers are checked first so a large RAM can never shadow them.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes);
        logic [31:0] word_addr;
        region_e     region;
        word_addr = {addr[31:2], 2'b00};
        if (word_addr == STATUS_ADDR)      region = REGION_STATUS;
        else if (word_addr == PIXEL_ADDR)  region = REGION_PIXEL;
        else if (word_addr == CTRL_ADDR)   region = REGION_CTRL;
        else if (word_addr == CYCLES_ADDR) region = REGION_CYCLES;
        else if (word_addr < ram_bytes)    region = REGION_RAM;
        else                               region = REGION_NONE;
        return region;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
// Bundles the CPU memory-stage bus and the camera byte stream.
//   addr, write_enable, read_enable, write_data : CPU -> responder
//   read_data                                   : responder -> CPU (combinational)
//   pix_valid, pix_data                         : camera -> responder
//   pix_ready                                   : responder -> camera
// Handshake: a pixel byte transfers on a rising edge where pix_valid and
// pix_ready are both high. pix_ready never depends on pix_valid, and the
// camera must hold pix_data stable while pix_valid is high and pix_ready low.
interface data_mem_responder_if;

    logic [31:0] addr;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;

    modport master (
        output addr, write_enable, read_enable, write_data, pix_valid, pix_data,
        input  read_data, pix_ready
    );

    modport slave (
        input  addr, write_enable, read_enable, write_data, pix_valid, pix_data,
        output read_data, pix_ready
    );

endinterface

// File: rtl/pixel_fifo.sv
// pixel_fifo
// Word FIFO holding packed pixel words until the CPU reads them.
//   clk, reset     : clock, asynchronous active-low reset
//   push/push_data : enqueue a word (ignored while full)
//   pop            : dequeue the head word (ignored while empty)
//   flush          : empty the FIFO; wins over a same-edge push/pop
//   head           : current head word (stale while empty)
//   count          : number of stored words, 0..DEPTH
//   full, empty    : occupancy flags
module pixel_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [31:0]      push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [31:0]      head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap modulo DEPTH so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is data only and needs no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Memory-stage responder: word RAM plus memory-mapped camera registers.
//   clk   : single clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : data_mem_responder_if.slave
//     RAM    0x0000 .. RAM_WORDS*4-1 : combinational read, write on edge
//     STATUS 0x1000 (RO) : [0] empty, [1] full, [7:4] words, [9:8] packer bytes
//     PIXEL  0x1004      : FIFO head; a load pops it
//     CTRL   0x1008 (WO) : bit1 flushes FIFO and packer
//     CYCLES 0x100C      : free-running counter, writable
//   Camera bytes are packed little-endian into words and pushed on the
//   edge that accepts the fourth byte.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int RAM_WORDS  = DEFAULT_RAM_WORDS,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input logic                  clk,
    input logic                  reset,
    data_mem_responder_if.slave  bus
);

    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
    localparam int          RAM_AW    = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int          CNT_W     = $clog2(FIFO_DEPTH + 1);

    region_e           region;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       ram [RAM_WORDS];

    logic [1:0]        pack_cnt;
    logic [23:0]       pack_data;
    logic              accept;
    logic              flush;
    logic              fifo_push;
    logic              fifo_pop;
    logic [31:0]       fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [31:0]       status;
    logic [31:0]       cycles;

    assign region  = decode_region(bus.addr, RAM_BYTES);
    assign ram_idx = bus.addr[RAM_AW+1:2];

    // Only the byte that would complete a word can be refused, and only when
    // there is no slot for it; a same-cycle pop does not open the gate.
    assign bus.pix_ready = !((pack_cnt == 2'd3) && fifo_full);
    assign accept        = bus.pix_valid && bus.pix_ready;

    assign flush     = bus.write_enable && (region == REGION_CTRL)
                       && bus.write_data[CTRL_FLUSH_BIT];
    assign fifo_push = accept && (pack_cnt == 2'd3) && !flush;
    assign fifo_pop  = bus.read_enable && (region == REGION_PIXEL) && !flush;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({bus.pix_data, pack_data}),
        .pop       (fifo_pop),
        .flush     (flush),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Byte packer: holds bytes 0..2; byte 3 goes straight into the pushed word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pack_cnt  <= 2'd0;
            pack_data <= 24'd0;
        end else if (flush) begin
            pack_cnt  <= 2'd0;
            pack_data <= 24'd0;
        end else if (accept) begin
            pack_cnt <= pack_cnt + 2'd1;
            case (pack_cnt)
                2'd0:    pack_data[7:0]   <= bus.pix_data;
                2'd1:    pack_data[15:8]  <= bus.pix_data;
                2'd2:    pack_data[23:16] <= bus.pix_data;
                default: pack_data        <= pack_data;
            endcase
        end
    end

    // A CPU write to CYCLES takes the place of that edge's increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles <= 32'd0;
        end else if (bus.write_enable && (region == REGION_CYCLES)) begin
            cycles <= bus.write_data;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.write_enable && (region == REGION_RAM)) ram[ram_idx] <= bus.write_data;
    end

    always_comb begin
        status      = 32'd0;
        status[0]   = fifo_empty;
        status[1]   = fifo_full;
        status[7:4] = 4'(fifo_count);
        status[9:8] = pack_cnt;
    end

    always_comb begin
        bus.read_data = 32'd0;
        case (region)
            REGION_RAM:    bus.read_data = ram[ram_idx];
            REGION_STATUS: bus.read_data = status;
            REGION_PIXEL:  bus.read_data = fifo_empty ? 32'd0 : fifo_head;
            REGION_CYCLES: bus.read_data = cycles;
            default:       bus.read_data = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Randomized and directed stimulus for data_mem_responder. Expected
// {pix_ready, read_data} values come from a queue-based reference model
// (or from literal values for the directed scenarios) and are pushed into
// exp_q; a negedge monitor pops and compares them.
module tb_data_mem_responder;

    localparam int          DEPTH     = 8;
    localparam int          RAM_WORDS = 256;
    localparam logic [31:0] A_STATUS  = 32'h0000_1000;
    localparam logic [31:0] A_PIXEL   = 32'h0000_1004;
    localparam logic [31:0] A_CTRL    = 32'h0000_1008;
    localparam logic [31:0] A_CYCLES  = 32'h0000_100C;

    logic clk;
    logic reset;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .RAM_WORDS  (RAM_WORDS),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [31:0] m_ram    [RAM_WORDS];
    bit          m_ram_ok [RAM_WORDS];
    logic [7:0]  m_pk [$];     // bytes waiting to form a word
    logic [31:0] m_wq [$];     // words waiting for the CPU
    logic [31:0] m_cycles;

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = 32'd0;
        s[0]   = (m_wq.size() == 0);
        s[1]   = (m_wq.size() == DEPTH);
        s[7:4] = 4'(m_wq.size());
        s[9:8] = 2'(m_pk.size());
        return s;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (wa == A_STATUS)                return model_status();
        if (wa == A_PIXEL)                 return (m_wq.size() > 0) ? m_wq[0] : 32'd0;
        if (wa == A_CTRL)                  return 32'd0;
        if (wa == A_CYCLES)                return m_cycles;
        if (wa < 32'(RAM_WORDS * 4))       return m_ram[wa[9:2]];
        return 32'd0;
    endfunction

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q [$];
    string       name_q [$];
    logic        chk_valid;
    int          checks;
    int          errors;

    always @(negedge clk) begin
        if (chk_valid) begin
            logic [32:0] e;
            string       nm;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: DUT output with no expectation");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if ({bus.pix_ready, bus.read_data} !== e) begin
                    errors++;
                    $display("FAIL %s: got ready=%0b data=%h, want ready=%0b data=%h",
                             nm, bus.pix_ready, bus.read_data, e[32], e[31:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; drives one cycle, updates the model for the edge
    // that commits it, returns at the following posedge+1.
    task automatic drive(input logic [31:0] a, input logic we, input logic re,
                         input logic [31:0] wd, input logic pv, input logic [7:0] pd,
                         input logic chk, input logic fixed, input logic [32:0] fexp,
                         input string nm);
        logic [31:0] wa;
        logic        ready;
        logic        flush;
        logic [31:0] dummy;
        wa    = {a[31:2], 2'b00};
        ready = !(m_pk.size() == 3 && m_wq.size() == DEPTH);
        bus.addr         = a;
        bus.write_enable = we;
        bus.read_enable  = re;
        bus.write_data   = wd;
        bus.pix_valid    = pv;
        bus.pix_data     = pd;
        chk_valid        = chk;
        if (chk) begin
            exp_q.push_back(fixed ? fexp : {ready, model_read(a)});
            name_q.push_back(nm);
        end
        flush = we && (wa == A_CTRL) && wd[1];
        if (flush) begin
            m_wq.delete();
            m_pk.delete();
        end else begin
            if (re && wa == A_PIXEL && m_wq.size() > 0) dummy = m_wq.pop_front();
            if (pv && ready) begin
                m_pk.push_back(pd);
                if (m_pk.size() == 4) begin
                    m_wq.push_back({m_pk[3], m_pk[2], m_pk[1], m_pk[0]});
                    m_pk.delete();
                end
            end
        end
        if (we && wa < 32'(RAM_WORDS * 4)) begin
            m_ram[wa[9:2]]    = wd;
            m_ram_ok[wa[9:2]] = 1'b1;
        end
        m_cycles = (we && wa == A_CYCLES) ? wd : m_cycles + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input logic rdy, input logic [31:0] v, input string nm);
        drive(A_STATUS, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 1'b1, 1'b1, {rdy, v}, nm);
    endtask

    task automatic push_byte(input logic [7:0] b);
        drive(A_STATUS, 1'b0, 1'b0, 32'd0, 1'b1, b, 1'b0, 1'b0, 33'd0, "byte");
    endtask

    task automatic idle();
        drive(32'h0000_2000, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0, 33'd0, "idle");
    endtask

    // Reset is asserted at posedge+1 and sampled at the next negedge, so the
    // first check sees reset values before any clock edge.
    task automatic apply_reset(input logic chk);
        reset            = 1'b0;
        bus.addr         = A_STATUS;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
        bus.write_data   = 32'd0;
        bus.pix_valid    = 1'b0;
        bus.pix_data     = 8'd0;
        m_wq.delete();
        m_pk.delete();
        m_cycles  = 32'd0;
        chk_valid = chk;
        if (chk) begin
            exp_q.push_back({1'b1, 32'h0000_0001});
            name_q.push_back("reset_status");
        end
        @(posedge clk);
        #1;
        bus.addr  = A_CYCLES;
        chk_valid = chk;
        if (chk) begin
            exp_q.push_back({1'b1, 32'h0000_0000});
            name_q.push_back("reset_cycles");
        end
        @(posedge clk);
        #1;
        chk_valid = 1'b0;
        reset     = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        logic        we;
        logic        re;
        logic [31:0] wd;
        logic        pv;
        logic [7:0]  pd;
        logic        chk;
        int          w;
        logic [31:0] unmapped [5];

        unmapped[0] = 32'h0000_0400;
        unmapped[1] = 32'h0000_1010;
        unmapped[2] = 32'h0000_2000;
        unmapped[3] = 32'hFFFF_FFFC;
        unmapped[4] = 32'h0000_0FFC;
        checks    = 0;
        errors    = 0;
        chk_valid = 1'b0;
        reset     = 1'b0;
        bus.addr = 32'd0; bus.write_enable = 1'b0; bus.read_enable = 1'b0;
        bus.write_data = 32'd0; bus.pix_valid = 1'b0; bus.pix_data = 8'd0;
        m_cycles = 32'd0;
        for (int i = 0; i < RAM_WORDS; i++) m_ram_ok[i] = 1'b0;

        @(posedge clk);
        #1;
        apply_reset(1'b1);

        // RAM store/load, byte lanes ignored
        drive(32'h10, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 8'd0, 1'b0, 1'b0, 33'd0, "st10");
        drive(32'h10, 1'b0, 1'b1, 32'd0, 1'b0, 8'd0, 1'b1, 1'b1, {1'b1, 32'hDEADBEEF}, "ld10");
        drive(32'h13, 1'b0, 1'b1, 32'd0, 1'b0, 8'd0, 1'b1, 1'b1, {1'b1, 32'hDEADBEEF}, "ld13_lane");
        drive(32'h14, 1'b1, 1'b0, 32'h12345678, 1'b0, 8'd0, 1'b0, 1'b0, 33'd0, "st14a");
        drive(32'h14, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 8'd0, 1'b0, 1'b0, 33'd0, "st14b");
        drive(32'h14, 1'b0, 1'b1, 32'd0, 1'b0, 8'd0, 1'b1, 1'b1, {1'b1, 32'hCAFEF00D}, "ld14");
        drive(A_CTRL, 1'b0, 1'b1, 32'd0, 1'b0, 8'd0, 1'b1, 1'b1, {1'b1, 32'd0}, "ctrl_read");
        drive(32'h2000, 1'b1, 1'b0, 32'h5555AAAA, 1'b0, 8'd0, 1'b0, 1'b0, 33'd0, "st_unmapped");
        drive(32'h2000, 1'b0, 1'b1, 32'd0, 1'b0, 8'd0, 1'b1, 1'b1, {1'b1, 32'd0}, "ld_unmapped");

        // one packed word
        push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
        check_status(1'b1, 32'h0000_0010, "status_one_word");
        drive(A_PIXEL, 1'b0, 1'b1, 32'd0, 1'b0, 8'd0, 1'b1, 1'b1, {1'b1, 32'h44332211}, "pixel_word");
        check_status(1'b1, 32'h0000_0001, "status_after_pop");
        drive(A_PIXEL, 1'b0, 1'b1, 32'd0, 1'b0, 8'd0, 1'b1, 1'b1, {1'b1, 32'd0}, "pixel_empty");
        check_status(1'b1, 32'h0000_0001, "status_empty_pop");

        // fill to full, then stall the completing byte
        for (int i = 0; i < 32; i++) push_byte(8'(i));
        check_status(1'b1, 32'h0000_0082, "status_full");
        for (int i = 32; i < 35; i++) push_byte(8'(i));
        check_status(1'b0, 32'h0000_0382, "status_full_pk3");
        for (int i = 0; i < 3; i++)
            drive(A_STATUS, 1'b0, 1'b0, 32'd0, 1'b1, 8'd35, 1'b1, 1'b1, {1'b0, 32'h0000_0382}, "stall");
        drive(A_PIXEL, 1'b0, 1'b1, 32'd0, 1'b1, 8'd35, 1'b1, 1'b1, {1'b0, 32'h03020100}, "pop_no_bypass");
        drive(A_STATUS, 1'b0, 1'b0, 32'd0, 1'b1, 8'd35, 1'b1, 1'b1, {1'b1, 32'h0000_0370}, "status_after_pop_full");
        check_status(1'b1, 32'h0000_0082, "status_refull");
        drive(A_PIXEL, 1'b0, 1'b1, 32'd0, 1'b0, 8'd0, 1'b1, 1'b1, {1'b1, 32'h07060504}, "pixel_second");
        drive(A_CTRL, 1'b1, 1'b0, 32'h2, 1'b0, 8'd0, 1'b0, 1'b0, 33'd0, "flush");
        check_status(1'b1, 32'h0000_0001, "status_flushed");

        // flush on the same edge as a fourth-byte push
        push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
        drive(A_CTRL, 1'b1, 1'b0, 32'h2, 1'b1, 8'hDD, 1'b0, 1'b0, 33'd0, "flush_push");
        check_status(1'b1, 32'h0000_0001, "status_flush_push");

        // CYCLES wrap
        drive(A_CYCLES, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 8'd0, 1'b0, 1'b0, 33'd0, "cyc_load");
        idle();
        drive(A_CYCLES, 1'b0, 1'b1, 32'd0, 1'b0, 8'd0, 1'b1, 1'b1, {1'b1, 32'hFFFF_FFFF}, "cyc_max");
        drive(A_CYCLES, 1'b0, 1'b1, 32'd0, 1'b0, 8'd0, 1'b1, 1'b1, {1'b1, 32'h0000_0000}, "cyc_wrap");

        // reset mid-packing
        push_byte(8'h01); push_byte(8'h02);
        apply_reset(1'b1);
        check_status(1'b1, 32'h0000_0001, "status_post_reset");

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            a = 32'h0; we = 1'b0; re = 1'b0; wd = $urandom; chk = 1'b1;
            pv = ($urandom_range(0, 9) < 6);
            pd = 8'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    w   = $urandom_range(0, 63);
                    a   = 32'(w * 4) | 32'($urandom_range(0, 3));
                    we  = ($urandom_range(0, 2) == 0);
                    re  = 1'($urandom_range(0, 1));
                    chk = m_ram_ok[w];
                end
                3: a = A_STATUS;
                4, 5: begin
                    a  = A_PIXEL;
                    re = ($urandom_range(0, 4) != 0);
                end
                6: begin
                    a  = A_CTRL;
                    we = 1'b1;
                    wd = ($urandom_range(0, 7) == 0) ? 32'h2 : (wd & ~32'h2);
                end
                7: begin
                    a  = A_CYCLES;
                    we = ($urandom_range(0, 3) == 0);
                    re = 1'b1;
                end
                default: begin
                    a  = unmapped[$urandom_range(0, 4)];
                    we = 1'($urandom_range(0, 1));
                    re = 1'($urandom_range(0, 1));
                end
            endcase
            drive(a, we, re, wd, pv, pd, chk, 1'b0, 33'd0, "rand");
        end

        chk_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
